// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the micro-op record held by the
// operand stage and consumed by the ALU stage.
// Widths of uop_t follow ALU_N/ALU_R; the operand stage N/R must match them.
package alu_pkg;

    localparam int ALU_N = 32;
    localparam int ALU_R = 5;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_XOR  = 4'd1,
        OP_SUB  = 4'd2,
        OP_ADD  = 4'd3,
        OP_MOVE = 4'd4,
        OP_NOT  = 4'd5
    } alu_op_e;

    localparam logic [3:0] ALU_OP_MAX = 4'd5;

    typedef struct packed {
        logic [3:0]       alu_ctrl;
        logic [ALU_N-1:0] src_A;
        logic [ALU_N-1:0] src_B;
        logic [ALU_R-1:0] rd_idx;
        logic             rd_we;
        logic             illegal;
    } uop_t;

endpackage

// File: rtl/fwd_select.sv
// Per-source operand forwarding mux: x0 -> 0, then MEM, then WB, then regfile.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: idx/rf_val (source index and regfile data), mem_*/wb_* (bypass
// sources), val (resolved operand).
module fwd_select #(
    parameter int N = 32,
    parameter int R = 5
) (
    input  logic [R-1:0] idx,
    input  logic [N-1:0] rf_val,
    input  logic         mem_we,
    input  logic [R-1:0] mem_rd,
    input  logic [N-1:0] mem_data,
    input  logic         wb_we,
    input  logic [R-1:0] wb_rd,
    input  logic [N-1:0] wb_data,
    output logic [N-1:0] val
);

    always_comb begin
        val = rf_val;
        if (idx == '0) begin
            val = '0;
        end else if (mem_we && (mem_rd == idx)) begin
            // MEM holds the younger result, so it wins over WB
            val = mem_data;
        end else if (wb_we && (wb_rd == idx)) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Decode-to-ALU operand stage: forwarding resolve, imm select, 2-entry skid.
// Latency: 1 cycle accept-to-out_valid when empty (or one held and firing).
// Backpressure: valid/ready; in_ready = ~skid_valid & ~flush, outputs held while stalled.
// Ports: in_* (decoded micro-op + regfile data), fwd_* (MEM/WB bypass),
// out_* (registered ALU operands + dest info), flush (kills held ops).
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int N = 32,
    parameter int R = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_alu_ctrl,
    input  logic [R-1:0] in_rs1_idx,
    input  logic [R-1:0] in_rs2_idx,
    input  logic [N-1:0] in_rs1_val,
    input  logic [N-1:0] in_rs2_val,
    input  logic [N-1:0] in_imm,
    input  logic         in_use_imm,
    input  logic [R-1:0] in_rd_idx,
    input  logic         in_rd_we,
    input  logic         fwd_mem_we,
    input  logic [R-1:0] fwd_mem_rd,
    input  logic [N-1:0] fwd_mem_data,
    input  logic         fwd_wb_we,
    input  logic [R-1:0] fwd_wb_rd,
    input  logic [N-1:0] fwd_wb_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_alu_ctrl,
    output logic [N-1:0] out_src_A,
    output logic [N-1:0] out_src_B,
    output logic [R-1:0] out_rd_idx,
    output logic         out_rd_we,
    output logic         out_illegal
);

    // State encoding is {skid_valid, main_valid}
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_BAD   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_e;

    stage_state_e state_q, state_d;
    uop_t         main_q, skid_q, in_uop;
    logic [N-1:0] rs1_res, rs2_res;
    logic         main_valid, skid_valid, accept, fire;
    logic         load_main_in, load_main_skid, load_skid;

    fwd_select #(.N(N), .R(R)) u_fwd_rs1 (
        .idx(in_rs1_idx), .rf_val(in_rs1_val),
        .mem_we(fwd_mem_we), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data),
        .wb_we(fwd_wb_we), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .val(rs1_res)
    );

    fwd_select #(.N(N), .R(R)) u_fwd_rs2 (
        .idx(in_rs2_idx), .rf_val(in_rs2_val),
        .mem_we(fwd_mem_we), .mem_rd(fwd_mem_rd), .mem_data(fwd_mem_data),
        .wb_we(fwd_wb_we), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .val(rs2_res)
    );

    // Operands are frozen here at accept; held ops are never re-resolved.
    always_comb begin
        in_uop          = '0;
        in_uop.alu_ctrl = in_alu_ctrl;
        in_uop.src_A    = rs1_res;
        in_uop.src_B    = in_use_imm ? in_imm : rs2_res;
        in_uop.rd_idx   = in_rd_idx;
        in_uop.rd_we    = in_rd_we;
        in_uop.illegal  = (in_alu_ctrl > ALU_OP_MAX);
    end

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];
    // Depends only on skid state and flush, never on out_ready
    assign in_ready   = ~skid_valid & ~flush;
    assign accept     = in_valid & in_ready;
    assign fire       = main_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && fire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_uop;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_uop;
            end
        end
    end

    assign out_valid    = main_valid;
    assign out_alu_ctrl = main_q.alu_ctrl;
    assign out_src_A    = main_q.src_A;
    assign out_src_B    = main_q.src_B;
    assign out_rd_idx   = main_q.rd_idx;
    assign out_rd_we    = main_q.rd_we;
    assign out_illegal  = main_q.illegal;

endmodule
